alu_pipe: RTL and testbench

- Parametrised, registered successor to the team's 8-bit four-function ALU.
- Takes operands and an op code through a valid/ready input handshake and returns a registered result plus status flags through a valid/ready output handshake.
- Adds XOR, shifts, and a multi-cycle shift-add multiply.
- Sits between the operand/register-read stage and writeback in the datapath.

---
 rtl/alu_pipe.sv | 173 +++++++++++++++++
 tb/tb_alu_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Registered W-bit ALU with valid/ready handshakes and a W-cycle shift-add multiplier.
// Define ALU_SAT_EN to make ADD/SUB saturate on signed overflow.
module alu_pipe #(
  parameter int unsigned W = 8,
  localparam int unsigned SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] left,
  input  logic [W-1:0] right,
  input  logic [2:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] ALUout,
  output logic [3:0]   flags
);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpOr  = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpShl = 3'd5;
  localparam logic [2:0] OpShr = 3'd6;
  localparam logic [2:0] OpMul = 3'd7;

  localparam logic [SHW-1:0] CntLast = SHW'(W - 1);

  typedef enum logic [1:0] {StIdle, StMul, StHold} state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     alu_q, alu_d;
  logic [3:0]       flags_q, flags_d;
  logic [2*W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [2*W-1:0]   prod_q, prod_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic             accept;
  logic [SHW-1:0]   sh_amt;
  logic [W:0]       sum_w, diff_w, shl_w, shr_w;
  logic [W-1:0]     res_c;
  logic             c_c, v_c;
  logic [3:0]       flags_c;
  logic [2*W-1:0]   prod_step;

  assign in_ready  = ~rst & (state_q == StIdle) & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign ALUout    = alu_q;
  assign flags     = flags_q;

  assign sh_amt = right[SHW-1:0];
  assign sum_w  = {1'b0, left} + {1'b0, right};
  assign diff_w = {1'b0, left} - {1'b0, right};
  // Extra bit beside the operand catches the last bit shifted out (0 for a zero shift).
  assign shl_w  = {1'b0, left} << sh_amt;
  assign shr_w  = {left, 1'b0} >> sh_amt;

  always_comb begin
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    case (mode)
      OpAdd: begin
        res_c = sum_w[W-1:0];
        c_c   = sum_w[W];
        v_c   = (left[W-1] == right[W-1]) && (sum_w[W-1] != left[W-1]);
      end
      OpSub: begin
        res_c = diff_w[W-1:0];
        c_c   = diff_w[W];
        v_c   = (left[W-1] != right[W-1]) && (diff_w[W-1] != left[W-1]);
      end
      OpAnd: res_c = left & right;
      OpOr:  res_c = left | right;
      OpXor: res_c = left ^ right;
      OpShl: begin
        res_c = shl_w[W-1:0];
        c_c   = shl_w[W];
      end
      OpShr: begin
        res_c = shr_w[W:1];
        c_c   = shr_w[0];
      end
      default: res_c = '0;
    endcase
`ifdef ALU_SAT_EN
    // Overflow direction follows the sign of left for both ADD and SUB.
    if ((mode == OpAdd || mode == OpSub) && v_c) begin
      res_c = left[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
    flags_c = {res_c[W-1], v_c, c_c, (res_c == '0)};
  end

  assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    alu_d       = alu_q;
    flags_d     = flags_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    case (state_q)
      StIdle: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept) begin
          if (mode == OpMul) begin
            state_d  = StMul;
            mcand_d  = {{W{1'b0}}, left};
            mplier_d = right;
            prod_d   = '0;
            cnt_d    = '0;
          end else begin
            // Stay idle: in_ready already gates new work while the result is stalled.
            alu_d       = res_c;
            flags_d     = flags_c;
            out_valid_d = 1'b1;
          end
        end
      end
      StMul: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          alu_d       = prod_step[W-1:0];
          flags_d     = {prod_step[W-1], 1'b0, |prod_step[2*W-1:W], (prod_step[W-1:0] == '0)};
          out_valid_d = 1'b1;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      alu_q       <= '0;
      flags_q     <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_q       <= alu_d;
      flags_q     <= flags_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (W=8): stimulus pushes expected results, a monitor pops on handshake.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] left, right;
  logic [2:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] ALUout;
  logic [3:0] flags;

  int total = 0;
  int bad   = 0;
  logic [11:0] sb[$];

  alu_pipe #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .left      (left),
    .right     (right),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUout    (ALUout),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Monitor: a transfer happens on the next rising edge when both valid and ready are high.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result: got ALUout=%h flags=%b, none expected", ALUout, flags);
      end else begin
        logic [11:0] exp;
        exp = sb.pop_front();
        if ({ALUout, flags} !== exp) begin
          bad++;
          $display("FAIL result: got ALUout=%h flags=%b, want ALUout=%h flags=%b",
                   ALUout, flags, exp[11:4], exp[3:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] m, input logic [7:0] l, input logic [7:0] r,
                       input logic [7:0] er, input logic [3:0] ef, input bit push,
                       output int cyc);
    bit acc;
    if (push) sb.push_back({er, ef});
    in_valid = 1'b1;
    mode     = m;
    left     = l;
    right    = r;
    cyc      = 0;
    acc      = 1'b0;
    while (!acc && cyc < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    left     = 8'($urandom);
    right    = 8'($urandom);
    mode     = 3'($urandom);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept, want accept for mode %0d", m);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int cyc;
    int k;
    bit ir_low;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    left      = '0;
    right     = '0;
    mode      = '0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_aluout", ALUout, 0);
    chk("rst_flags", flags, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single-cycle ops, streamed back to back; flags are {N,V,C,Z}.
    issue(3'd0, 8'hF0, 8'h20, 8'h10, 4'b0010, 1, cyc);
    chk("add_latency", cyc, 1);
    chk("add_out_valid", out_valid, 1);
    issue(3'd1, 8'h05, 8'h05, 8'h00, 4'b0001, 1, cyc);
`ifdef ALU_SAT_EN
    issue(3'd0, 8'h7F, 8'h01, 8'h7F, 4'b0100, 1, cyc);
    issue(3'd1, 8'h80, 8'h01, 8'h80, 4'b1100, 1, cyc);
    issue(3'd0, 8'h80, 8'h80, 8'h80, 4'b1110, 1, cyc);
`else
    issue(3'd0, 8'h7F, 8'h01, 8'h80, 4'b1100, 1, cyc);
    issue(3'd1, 8'h80, 8'h01, 8'h7F, 4'b0100, 1, cyc);
    issue(3'd0, 8'h80, 8'h80, 8'h00, 4'b0111, 1, cyc);
`endif
    issue(3'd1, 8'h00, 8'h01, 8'hFF, 4'b1010, 1, cyc);
    issue(3'd3, 8'h0F, 8'hF0, 8'hFF, 4'b1000, 1, cyc);
    issue(3'd4, 8'hA5, 8'hFF, 8'h5A, 4'b0000, 1, cyc);
    issue(3'd5, 8'h81, 8'h01, 8'h02, 4'b0010, 1, cyc);
    issue(3'd6, 8'h81, 8'h00, 8'h81, 4'b1000, 1, cyc);
    issue(3'd6, 8'h01, 8'h07, 8'h00, 4'b0001, 1, cyc);
    issue(3'd5, 8'h81, 8'hF8, 8'h81, 4'b1000, 1, cyc);
    drain();

    // Multiply latency: result on the 8th edge after accept, in_ready low throughout.
    issue(3'd7, 8'h0C, 8'h0B, 8'h84, 4'b1000, 1, cyc);
    k = 0;
    ir_low = 1'b1;
    while (!out_valid && k < 50) begin
      if (in_ready) ir_low = 1'b0;
      @(posedge clk);
      #1;
      k++;
    end
    if (in_ready) ir_low = 1'b0;
    chk("mul_latency", k, 8);
    chk("mul_in_ready_low", ir_low, 1);
    drain();
    issue(3'd7, 8'h10, 8'h10, 8'h00, 4'b0011, 1, cyc);
    drain();

    // Backpressure on a single-cycle result, then release together with a new op.
    out_ready = 1'b0;
    issue(3'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1, cyc);
    for (int i = 0; i < 5; i++) begin
      chk("bp_aluout", ALUout, 8'h30);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    issue(3'd4, 8'h0F, 8'h01, 8'h0E, 4'b0000, 1, cyc);
    chk("no_bubble", cyc, 1);
    drain();

    // Abort a multiply with reset during its third cycle.
    issue(3'd4, 8'hA5, 8'hFF, 8'h5A, 4'b0000, 1, cyc);
    drain();
    issue(3'd7, 8'h03, 8'h05, 8'h0F, 4'b0000, 0, cyc);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_aluout", ALUout, 0);
    chk("abort_flags", flags, 0);
    chk("abort_in_ready", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_release_in_ready", in_ready, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_stale", out_valid, 0);
    issue(3'd0, 8'h01, 8'h02, 8'h03, 4'b0000, 1, cyc);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
